id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register for the pipelined processor. It sits directly downstream of the register file and captures the two read operands, immediate and decoded control each cycle.
- On the capture edge it applies a write-back bypass for same-cycle register writes. It also precomputes EX-stage forwarding selects.
- It detects load-use hazards and inserts bubbles on stall or branch flush.

Parameters:
- DATA_W, 32, operand/immediate width
- ADDR_W, 5, register address width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a valid instruction
- id_rs_addr  in  ADDR_W  source register 1 address (register file RSaddr)
- id_rt_addr  in  ADDR_W  source register 2 address (register file RTaddr)
- id_rd_addr  in  ADDR_W  destination (decoder supplies rt for loads)
- id_rs_data  in  DATA_W  register file read data 1
- id_rt_data  in  DATA_W  register file read data 2
- id_imm  in  DATA_W  sign-extended immediate
- id_ctrl  in  8  {reg_write, mem_read, mem_write, mem_to_reg, alu_src, alu_op[2:0]}
- flush  in  1  branch taken, kill ID instruction
- exmem_reg_write  in  1  EX/MEM instruction writes a register
- exmem_rd_addr  in  ADDR_W  EX/MEM destination
- wb_reg_write  in  1  WB write enable (same as register file RegWrite)
- wb_rd_addr  in  ADDR_W  WB destination (register file write address)
- wb_data  in  DATA_W  WB write data
- ex_valid  out  1  EX stage holds a valid instruction
- ex_rs_data  out  DATA_W  latched operand A
- ex_rt_data  out  DATA_W  latched operand B
- ex_imm  out  DATA_W  latched immediate
- ex_rs_addr, ex_rt_addr, ex_rd_addr  out  ADDR_W  latched addresses
- ex_ctrl  out  8  latched control, same field order as id_ctrl
- ex_fwd_a, ex_fwd_b  out  2  forwarding selects: 00 register, 01 MEM/WB, 10 EX/MEM
- stall  out  1  combinational; hold PC and IF/ID
- stall_count  out  CNT_W  cycles with stall asserted, saturating

Behaviour:
- Reset (async, rst_n=0): all registered outputs 0, which makes stall 0.
- stall = !flush & id_valid & ex_valid & ex_ctrl[6] & (ex_rd_addr!=0) & (ex_rd_addr==id_rs_addr | ex_rd_addr==id_rt_addr).
- Bubble on a rising edge when flush | stall | !id_valid:
  - ex_valid, ex_ctrl, ex_fwd_a, ex_fwd_b, all data and address fields go to 0.
  - Flush has priority over stall and suppresses stall that cycle.
- Capture otherwise: ex_valid=1; addresses, imm and ctrl are copied, with 1-cycle latency.
- Operand A capture priority:
  - id_rs_addr==0 gives 0.
  - Else, if wb_reg_write and wb_rd_addr==id_rs_addr, capture wb_data (write-back bypass).
  - Else capture id_rs_data.
- Operand B uses the same rule with rt.
- ex_fwd_a is computed from pre-edge state and registered:
  - 10 if ex_valid & ex_ctrl[7] & ex_rd_addr!=0 & ex_rd_addr==id_rs_addr.
  - Else 01 if exmem_reg_write & exmem_rd_addr!=0 & exmem_rd_addr==id_rs_addr.
  - Else 00.
- ex_fwd_b uses the same rule with rt.
- The newer producer (10) always wins over 01.
- A load in ID/EX never produces 10, because that case stalls.
- Address 0 never matches in the hazard, bypass or forward logic.
- stall_count increments on every rising edge where stall=1 and holds at all-ones.
- Back-to-back stalls: after one bubble the load leaves ID/EX, so stall deasserts and the held instruction is captured with fwd 01.

Test Plan:
- Reset mid-stream: assert rst_n=0 asynchronously between edges -> all outputs 0 immediately and stall=0.
- ALU chain: captured add writes r5 (ex_ctrl=8'h80), next ID reads rs=5 -> after the edge ex_fwd_a=10, ex_valid=1, no stall.
- Load-use: lw with rd=8 in ID/EX (ctrl bit6=1), ID reads rt=8 -> stall=1 for exactly 1 cycle, bubble ex_valid=0, stall_count=1; next edge captures with ex_fwd_b=01.
- WB bypass: wb_reg_write=1, wb_rd_addr=3, wb_data=32'hDEAD_BEEF, id_rs_addr=3, id_rs_data=74 -> ex_rs_data=32'hDEADBEEF.
- Register zero: all producers target r0, ID reads rs=rt=0 -> ex_rs_data=0, ex_rt_data=0, fwd 00, stall=0.
- Flush during load-use: stall condition true and flush=1 -> stall=0, bubble captured, stall_count unchanged.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass,
// EX forwarding select precompute and load-use stall.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs_addr,
  input  logic [ADDR_W-1:0] id_rt_addr,
  input  logic [ADDR_W-1:0] id_rd_addr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [7:0]        id_ctrl,
  input  logic              flush,
  input  logic              exmem_reg_write,
  input  logic [ADDR_W-1:0] exmem_rd_addr,
  input  logic              wb_reg_write,
  input  logic [ADDR_W-1:0] wb_rd_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [ADDR_W-1:0] ex_rs_addr,
  output logic [ADDR_W-1:0] ex_rt_addr,
  output logic [ADDR_W-1:0] ex_rd_addr,
  output logic [7:0]        ex_ctrl,
  output logic [1:0]        ex_fwd_a,
  output logic [1:0]        ex_fwd_b,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic              r_valid;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [ADDR_W-1:0] r_rs_addr;
  logic [ADDR_W-1:0] r_rt_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [7:0]        r_ctrl;
  logic [1:0]        r_fwd_a;
  logic [1:0]        r_fwd_b;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_rd_nz;
  logic              w_hit_rs;
  logic              w_hit_rt;
  logic              w_stall;
  logic              w_bubble;
  logic              w_ex_prod;
  logic              w_mem_prod;
  logic              w_wb_rs;
  logic              w_wb_rt;
  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_op_b;
  logic [1:0]        w_fwd_a;
  logic [1:0]        w_fwd_b;

  assign w_rd_nz  = (r_rd_addr != '0);
  assign w_hit_rs = (r_rd_addr == id_rs_addr);
  assign w_hit_rt = (r_rd_addr == id_rt_addr);

  // Load in ID/EX feeding the ID instruction; flush overrides.
  assign w_stall = !flush && id_valid && r_valid
                 && r_ctrl[6] && w_rd_nz
                 && (w_hit_rs || w_hit_rt);

  assign w_bubble = flush || w_stall || !id_valid;

  assign w_wb_rs = wb_reg_write
                 && (wb_rd_addr == id_rs_addr);
  assign w_wb_rt = wb_reg_write
                 && (wb_rd_addr == id_rt_addr);

  assign w_op_a = (id_rs_addr == '0) ? '0
                : w_wb_rs ? wb_data : id_rs_data;
  assign w_op_b = (id_rt_addr == '0) ? '0
                : w_wb_rt ? wb_data : id_rt_data;

  assign w_ex_prod  = r_valid && r_ctrl[7] && w_rd_nz;
  assign w_mem_prod = exmem_reg_write
                    && (exmem_rd_addr != '0);

  assign w_fwd_a =
    (w_ex_prod && w_hit_rs) ? 2'b10 :
    (w_mem_prod && exmem_rd_addr == id_rs_addr)
      ? 2'b01 : 2'b00;

  assign w_fwd_b =
    (w_ex_prod && w_hit_rt) ? 2'b10 :
    (w_mem_prod && exmem_rd_addr == id_rt_addr)
      ? 2'b01 : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_rs_addr <= '0;
      r_rt_addr <= '0;
      r_rd_addr <= '0;
      r_ctrl    <= '0;
      r_fwd_a   <= '0;
      r_fwd_b   <= '0;
    end else if (w_bubble) begin
      r_valid   <= 1'b0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_rs_addr <= '0;
      r_rt_addr <= '0;
      r_rd_addr <= '0;
      r_ctrl    <= '0;
      r_fwd_a   <= '0;
      r_fwd_b   <= '0;
    end else begin
      r_valid   <= 1'b1;
      r_rs_data <= w_op_a;
      r_rt_data <= w_op_b;
      r_imm     <= id_imm;
      r_rs_addr <= id_rs_addr;
      r_rt_addr <= id_rt_addr;
      r_rd_addr <= id_rd_addr;
      r_ctrl    <= id_ctrl;
      r_fwd_a   <= w_fwd_a;
      r_fwd_b   <= w_fwd_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_stall && r_cnt != '1) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign ex_valid    = r_valid;
  assign ex_rs_data  = r_rs_data;
  assign ex_rt_data  = r_rt_data;
  assign ex_imm      = r_imm;
  assign ex_rs_addr  = r_rs_addr;
  assign ex_rt_addr  = r_rt_addr;
  assign ex_rd_addr  = r_rd_addr;
  assign ex_ctrl     = r_ctrl;
  assign ex_fwd_a    = r_fwd_a;
  assign ex_fwd_b    = r_fwd_b;
  assign stall       = w_stall;
  assign stall_count = r_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed
// hazard cases then randomized traffic.
module tb_id_ex_stage;

  typedef struct packed {
    logic        v;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsd, rtd, imm;
    logic [7:0]  ctrl;
    logic        fl;
    logic        emw;
    logic [4:0]  emrd;
    logic        wbw;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
  } stim_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] a, b, imm;
    logic [4:0]  rs, rt, rd;
    logic [7:0]  ctrl;
    logic [1:0]  fa, fb;
  } exs_t;

  typedef struct packed {
    logic        st;
    exs_t        e;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid, flush;
  logic [4:0] id_rs_addr, id_rt_addr, id_rd_addr;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [7:0] id_ctrl;
  logic exmem_reg_write, wb_reg_write;
  logic [4:0] exmem_rd_addr, wb_rd_addr;
  logic [31:0] wb_data;
  logic ex_valid, stall;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0] ex_rs_addr, ex_rt_addr, ex_rd_addr;
  logic [7:0] ex_ctrl;
  logic [1:0] ex_fwd_a, ex_fwd_b;
  logic [15:0] stall_count;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid),
    .id_rs_addr(id_rs_addr),
    .id_rt_addr(id_rt_addr),
    .id_rd_addr(id_rd_addr),
    .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_ctrl(id_ctrl),
    .flush(flush),
    .exmem_reg_write(exmem_reg_write),
    .exmem_rd_addr(exmem_rd_addr),
    .wb_reg_write(wb_reg_write),
    .wb_rd_addr(wb_rd_addr),
    .wb_data(wb_data),
    .ex_valid(ex_valid),
    .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm),
    .ex_rs_addr(ex_rs_addr),
    .ex_rt_addr(ex_rt_addr),
    .ex_rd_addr(ex_rd_addr),
    .ex_ctrl(ex_ctrl),
    .ex_fwd_a(ex_fwd_a),
    .ex_fwd_b(ex_fwd_b),
    .stall(stall),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  exp_t q[$];
  exs_t ms = '0;
  logic [15:0] mcnt = '0;

  task automatic chk(input string n,
                     input logic [63:0] g,
                     input logic [63:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", n, g, e);
    end
  endtask

  // Reference: what the EX latch should hold after an edge.
  function automatic logic [31:0] opnd(
      input logic [4:0] r, input logic [31:0] d,
      input stim_t s);
    if (r == 0) return 0;
    if (s.wbw && s.wbrd == r) return s.wbd;
    return d;
  endfunction

  function automatic logic [1:0] fsel(
      input exs_t c, input stim_t s,
      input logic [4:0] r);
    if (c.valid && c.ctrl[7] && c.rd != 0 && c.rd == r)
      return 2'b10;
    if (s.emw && s.emrd != 0 && s.emrd == r)
      return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic hazard(
      input exs_t c, input stim_t s);
    if (s.fl || !s.v || !c.valid) return 0;
    if (!c.ctrl[6] || c.rd == 0) return 0;
    return (c.rd == s.rs) || (c.rd == s.rt);
  endfunction

  function automatic exs_t nxt(
      input exs_t c, input stim_t s, input logic st);
    exs_t n;
    n = '0;
    if (s.fl || st || !s.v) return n;
    n.valid = 1;
    n.a = opnd(s.rs, s.rsd, s);
    n.b = opnd(s.rt, s.rtd, s);
    n.imm = s.imm;
    n.rs = s.rs; n.rt = s.rt; n.rd = s.rd;
    n.ctrl = s.ctrl;
    n.fa = fsel(c, s, s.rs);
    n.fb = fsel(c, s, s.rt);
    return n;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 64'(ex_valid), 0);
    chk({tag, "_data"},
        {ex_rs_data, ex_rt_data} | 64'(ex_imm), 0);
    chk({tag, "_misc"},
        {ex_rs_addr, ex_rt_addr, ex_rd_addr,
         ex_ctrl, ex_fwd_a, ex_fwd_b}, 0);
    chk({tag, "_stall"}, 64'(stall), 0);
    chk({tag, "_cnt"}, 64'(stall_count), 0);
  endtask

  task automatic go(input stim_t s, input bit rst);
    exp_t x;
    @(negedge clk);
    rst_n = 1'b1;
    id_valid = s.v; flush = s.fl;
    id_rs_addr = s.rs; id_rt_addr = s.rt;
    id_rd_addr = s.rd;
    id_rs_data = s.rsd; id_rt_data = s.rtd;
    id_imm = s.imm; id_ctrl = s.ctrl;
    exmem_reg_write = s.emw;
    exmem_rd_addr = s.emrd;
    wb_reg_write = s.wbw; wb_rd_addr = s.wbrd;
    wb_data = s.wbd;
    #1;
    x.st = hazard(ms, s);
    x.e = nxt(ms, s, x.st);
    if (x.st && mcnt != 16'hFFFF) mcnt = mcnt + 1;
    if (rst) begin
      x.e = '0;
      mcnt = '0;
    end
    x.cnt = mcnt;
    ms = x.e;
    q.push_back(x);
    if (rst) begin
      #2 rst_n = 1'b0;
      #1 check_zero("mid_reset");
    end
  endtask

  // Monitor: stall before the edge, latch after it.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        x = q.pop_front();
        chk("stall", 64'(stall), 64'(x.st));
        @(posedge clk);
        #1;
        chk("ex_valid", 64'(ex_valid), 64'(x.e.valid));
        chk("ex_rs_data", 64'(ex_rs_data), 64'(x.e.a));
        chk("ex_rt_data", 64'(ex_rt_data), 64'(x.e.b));
        chk("ex_imm", 64'(ex_imm), 64'(x.e.imm));
        chk("ex_addr",
            {ex_rs_addr, ex_rt_addr, ex_rd_addr},
            {x.e.rs, x.e.rt, x.e.rd});
        chk("ex_ctrl", 64'(ex_ctrl), 64'(x.e.ctrl));
        chk("ex_fwd", {ex_fwd_a, ex_fwd_b},
            {x.e.fa, x.e.fb});
        chk("stall_count", 64'(stall_count),
            64'(x.cnt));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    stim_t s;
    {id_valid, flush, id_rs_addr, id_rt_addr,
     id_rd_addr, id_rs_data, id_rt_data, id_imm,
     id_ctrl, exmem_reg_write, exmem_rd_addr,
     wb_reg_write, wb_rd_addr, wb_data} = '0;
    #1 check_zero("reset");

    // ALU chain: add r5, then read r5.
    s = '0; s.v = 1;
    s.rs = 1; s.rt = 2; s.rd = 5;
    s.rsd = 11; s.rtd = 22; s.ctrl = 8'h80;
    go(s, 0);
    s.rs = 5; s.rt = 6; s.rd = 7; go(s, 0);

    // Load-use on rt, then captured with 01.
    s.rs = 1; s.rt = 2; s.rd = 8;
    s.ctrl = 8'hC8; go(s, 0);
    s.rs = 3; s.rt = 8; s.rd = 9;
    s.ctrl = 8'h80; go(s, 0);
    s.emw = 1; s.emrd = 8; go(s, 0);

    // WB bypass beats register file data.
    s.emw = 0; s.rs = 3; s.rt = 4;
    s.rsd = 74; s.wbw = 1; s.wbrd = 3;
    s.wbd = 32'hDEAD_BEEF; go(s, 0);

    // Everything aimed at r0.
    s.rd = 0; s.rs = 0; s.rt = 0;
    s.emw = 1; s.emrd = 0; s.wbrd = 0;
    go(s, 0); go(s, 0);

    // Flush during a load-use hazard.
    s.wbw = 0; s.emw = 0;
    s.rs = 1; s.rt = 2; s.rd = 8;
    s.ctrl = 8'hC0; go(s, 0);
    s.rt = 8; s.fl = 1; go(s, 0);
    s.fl = 0; s.rt = 1; go(s, 0);

    // Load then reset mid-stream.
    s.rd = 8; go(s, 0);
    s.rt = 8; go(s, 1);

    for (int i = 0; i < 400; i++) begin
      s.v = ($urandom_range(9) != 0);
      s.fl = ($urandom_range(9) == 0);
      s.rs = 5'($urandom_range(7));
      s.rt = 5'($urandom_range(7));
      s.rd = 5'($urandom_range(7));
      s.rsd = $urandom; s.rtd = $urandom;
      s.imm = $urandom;
      s.ctrl = 8'($urandom);
      s.emw = 1'($urandom);
      s.emrd = 5'($urandom_range(7));
      s.wbw = 1'($urandom);
      s.wbrd = 5'($urandom_range(7));
      s.wbd = $urandom;
      go(s, $urandom_range(59) == 0);
    end

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 64'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
